writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Parametrised write-back stage: accepts retiring ops from MEM, selects ALU result or loaded data,
//  sizes/aligns/extends loads, buffers ops in a DEPTH-entry FIFO, drains them to the register-file
//  write port under a ready handshake. Sits between MEM stage and the register file; absorbs
//  write-port stalls (shared port) without stalling MEM until the FIFO is full.
// PARAMETERS
//  XLEN        64  datapath width (32 or 64)
//  REG_ADDR_W  5   register index width
//  DEPTH       2   buffer entries (>=1, power of 2)
// PORTS
//  clk           in   1            clock, all state updates on rising edge
//  reset         in   1            synchronous, active-high reset
//  in_valid      in   1            MEM presents an op
//  in_ready      out  1            queue can accept (= !full)
//  in_reg        in   REG_ADDR_W   destination register
//  in_result     in   XLEN         ALU result
//  in_load_data  in   XLEN         raw memory word
//  in_mem_to_reg in   1            1: write loaded data, 0: write result
//  in_reg_write  in   1            op writes a register
//  in_size       in   2            load size 0=B 1=H 2=W 3=D
//  in_unsigned   in   1            zero-extend load (else sign-extend)
//  in_byte_off   in   $clog2(XLEN/8) byte offset of load within in_load_data
//  wr_valid      out  1            register-file write request
//  wr_ready      in   1            register file accepts write this cycle
//  wr_reg        out  REG_ADDR_W   write index
//  wr_data       out  XLEN         write data
//  busy          out  1            queue non-empty (hazard hint to decode)
// BEHAVIOUR
//  - Reset: count, rd/wr pointers, retire counter = 0; wr_valid=0, wr_reg=0, wr_data=0, busy=0,
//    in_ready=1 on the first cycle after reset deasserts. Reset mid-operation discards all entries.
//  - Enqueue when in_valid&&in_ready: data formatted at enqueue, stored as {reg, data, writes};
//    writes = in_reg_write && (in_reg!=0). Register 0 is never written.
//  - Load format: shift in_load_data right by 8*in_byte_off; offset low bits ignored per size
//    (H ignores bit0, W bits[1:0], D all); take 8/16/32/64 bits; extend per in_unsigned to XLEN.
//    XLEN=32: size 3 treated as W. mem_to_reg=0: in_result passes unmodified.
//  - Head presented registered: wr_valid = !empty && head.writes; wr_reg/wr_data = head fields
//    (hold last values when wr_valid=0). Latency: accept cycle N -> wr_valid in cycle N+1 if empty.
//  - Dequeue: head retires when !empty && (!head.writes || wr_ready). Non-writing ops retire in one
//    cycle without asserting wr_valid. wr_valid stays asserted, fields stable, until wr_ready.
//  - Full: in_ready=0; no same-cycle pass-through even if head retires (in_ready depends on count
//    only). Empty: wr_valid=0, busy=0. Simultaneous enq+deq: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1. Order strictly FIFO.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output retire_count [63:0], +1 on every dequeue (writing or
//  not), cleared by reset, wraps at 2^64. Undefined: port and counter absent, no other change.
// STRUCTURE
//  Package wb_pkg: size encodings WB_SZ_B/H/W/D, entry struct typedef (reg, data, writes),
//  helper function for extension. Sub-module wb_load_align: combinational shift/size/extend of the
//  load word; queue storage, pointers and handshake live in writeback_queue.
// TESTING
//  1 ALU op: in_result=64'h1234, reg=5, mem_to_reg=0, wr_ready=1 -> next cycle wr_valid, wr_reg=5,
//    wr_data=64'h1234; queue empty after.
//  2 Load B signed: load_data=64'h0000_0000_0000_80FF, off=1, size=0 -> wr_data=64'hFFFF_FFFF_FFFF_FF80;
//    same with unsigned=1 -> 64'h80; size=1 off=0 signed -> 64'hFFFF_FFFF_FFFF_80FF.
//  3 Reg 0 / reg_write=0: op retires in 1 cycle, wr_valid never high, busy drops next cycle.
//  4 Backpressure DEPTH=2: wr_ready=0, 3 valid ops -> first two accepted, in_ready=0 on third;
//    raise wr_ready -> writes retire in order 1,2,3, wr fields stable while stalled.
//  5 Reset mid-stall with 2 entries: reset 1 cycle -> wr_valid=0, busy=0, in_ready=1, no stale write.
//  6 WB_RETIRE_CNT_EN: 10 ops (3 to reg 0) -> retire_count=10 after drain; reset -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back queue.
// Contents: load size encodings, queue entry layout, load extension function.
// Entry fields are sized for the widest supported build (XLEN=64, 5-bit
// register index); narrower instances zero-extend into them.
package wb_pkg;

  localparam int unsigned WB_XLEN  = 64;
  localparam int unsigned WB_REG_W = 5;

  typedef enum logic [1:0] {
    WB_SZ_B = 2'd0,
    WB_SZ_H = 2'd1,
    WB_SZ_W = 2'd2,
    WB_SZ_D = 2'd3
  } wb_size_e;

  typedef struct packed {
    logic [WB_REG_W-1:0] rd;
    logic [WB_XLEN-1:0]  data;
    logic                writes;
  } wb_entry_t;

  // Keep the low 8/16/32/64 bits of v and extend them to 64 bits.
  function automatic logic [63:0] wb_extend(input logic [63:0] v,
                                            input logic [1:0]  size,
                                            input logic        is_unsigned);
    logic [63:0] r;
    case (size)
      WB_SZ_B: r = {{56{!is_unsigned && v[7]}},  v[7:0]};
      WB_SZ_H: r = {{48{!is_unsigned && v[15]}}, v[15:0]};
      WB_SZ_W: r = {{32{!is_unsigned && v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter: shifts the raw memory word down to the
// addressed bytes, truncates to the access size and sign/zero extends.
// Ports: load_data/size/is_unsigned/byte_off in, data_out out.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  load_data,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [OFF_W-1:0] byte_off,
  output logic [XLEN-1:0]  data_out
);

  logic [1:0]       size_eff;
  logic [OFF_W-1:0] off_mask;
  logic [OFF_W-1:0] off_eff;
  logic [XLEN-1:0]  shifted;
  logic [63:0]      ext;

  always_comb begin
    size_eff = size;
    // A 32-bit datapath has no doubleword loads; treat them as words.
    if ((XLEN == 32) && (size == WB_SZ_D)) size_eff = WB_SZ_W;
    // Natural alignment: drop the offset bits below the access size.
    off_mask = {OFF_W{1'b1}} << size_eff;
    off_eff  = byte_off & off_mask;
    shifted  = load_data >> {off_eff, 3'b000};
    ext      = wb_extend(64'(shifted), size_eff, is_unsigned);
    data_out = ext[XLEN-1:0];
  end

endmodule

// File: rtl/writeback_queue.sv
// Write-back stage: formats retiring MEM ops, buffers them in a DEPTH-entry
// FIFO and drains them to the register-file write port (valid/ready).
// Ports: clk, reset (sync, active-high); in_* enqueue side with in_ready;
// wr_valid/wr_ready/wr_reg/wr_data write port; busy = queue non-empty.
// Build option: WB_RETIRE_CNT_EN adds retire_count[63:0], incremented on
// every dequeue.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_W-1:0]     in_reg,
  input  logic [XLEN-1:0]           in_result,
  input  logic [XLEN-1:0]           in_load_data,
  input  logic                      in_mem_to_reg,
  input  logic                      in_reg_write,
  input  logic [1:0]                in_size,
  input  logic                      in_unsigned,
  input  logic [$clog2(XLEN/8)-1:0] in_byte_off,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [REG_ADDR_W-1:0]     wr_reg,
  output logic [XLEN-1:0]           wr_data,
  output logic                      busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_count
`endif
);

  localparam int unsigned OFF_W = $clog2(XLEN/8);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0] count, count_mid, count_n;
  logic [XLEN-1:0]  load_fmt;
  wb_entry_t        enq_entry, head_n;
  logic             enq, deq, head_vld_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  wb_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .load_data   (in_load_data),
    .size        (in_size),
    .is_unsigned (in_unsigned),
    .byte_off    (in_byte_off),
    .data_out    (load_fmt)
  );

  // Handshake, pointer/count update and the head entry for the next cycle.
  always_comb begin
    enq = in_valid && in_ready;
    // wr_valid mirrors head.writes whenever the queue is non-empty.
    deq = (count != '0) && (!wr_valid || wr_ready);

    enq_entry.rd     = WB_REG_W'(in_reg);
    enq_entry.data   = WB_XLEN'(in_mem_to_reg ? load_fmt : in_result);
    enq_entry.writes = in_reg_write && (in_reg != '0);

    rd_ptr_n  = deq ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_n  = enq ? ptr_inc(wr_ptr) : wr_ptr;
    count_mid = count - CNT_W'(deq);
    count_n   = count_mid + CNT_W'(enq);

    // If nothing older survives this cycle, the new entry becomes head
    // before it is visible in storage.
    head_n     = (count_mid == '0) ? enq_entry : mem[rd_ptr_n];
    head_vld_n = (count_n != '0);
  end

  // Queue storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_entry;
  end

  // Control state and registered write-port / status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wr_valid <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      count    <= count_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      busy     <= head_vld_n;
      in_ready <= (count_n != CNT_W'(DEPTH));
      wr_valid <= head_vld_n && head_n.writes;
      // Fields hold their last values while no write is requested.
      if (head_vld_n && head_n.writes) begin
        wr_reg  <= head_n.rd[REG_ADDR_W-1:0];
        wr_data <= head_n.data[XLEN-1:0];
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retirement counter, writing and non-writing ops alike.
  always_ff @(posedge clk) begin
    if (reset)    retire_count <= '0;
    else if (deq) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a scoreboard of expected writes.
module tb_writeback_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RW    = 5;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [RW-1:0]   in_reg;
  logic [XLEN-1:0] in_result, in_load_data;
  logic            in_mem_to_reg, in_reg_write, in_unsigned;
  logic [1:0]      in_size;
  logic [2:0]      in_byte_off;
  logic            wr_valid, wr_ready;
  logic [RW-1:0]   wr_reg;
  logic [XLEN-1:0] wr_data;
  logic            busy;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]     retire_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [RW+XLEN-1:0] sb[$];

  always #5 clk = ~clk;

  writeback_queue #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_result     (in_result),
    .in_load_data  (in_load_data),
    .in_mem_to_reg (in_mem_to_reg),
    .in_reg_write  (in_reg_write),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_byte_off   (in_byte_off),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .busy          (busy)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every completed register-file write must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed reg=%0d data=%h expected=none", wr_reg, wr_data);
      end
      if (sb.size() != 0) begin
        logic [RW+XLEN-1:0] e;
        e = sb.pop_front();
        chk("sb_wr_reg",  64'(wr_reg), 64'(e[RW+XLEN-1:XLEN]));
        chk("sb_wr_data", wr_data,     e[XLEN-1:0]);
      end
    end
  end

  // Present one op, wait (bounded) for in_ready, complete the transfer.
  task automatic enq(input logic [RW-1:0] r, input logic [63:0] res, input logic [63:0] ld,
                     input logic m2r, input logic rwr, input logic [1:0] sz,
                     input logic uns, input logic [2:0] off, input logic [63:0] exp_data);
    int n = 0;
    in_valid = 1'b1; in_reg = r; in_result = res; in_load_data = ld;
    in_mem_to_reg = m2r; in_reg_write = rwr; in_size = sz;
    in_unsigned = uns; in_byte_off = off;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("enq_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    if (rwr && r != '0) sb.push_back({r, exp_data});
  endtask

  // Let the queue empty (bounded) with the write port ready.
  task automatic drain();
    int n = 0;
    wr_ready = 1'b1;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_result = '0; in_load_data = '0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_byte_off = '0; wr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_wr_reg",   64'(wr_reg),   64'd0);
    chk("rst_wr_data",  wr_data,       64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_count", retire_count, 64'd0);
`endif

    // ALU op: visible the cycle after acceptance, gone one cycle later
    wr_ready = 1'b1;
    enq(5'd5, 64'h1234, 64'hFFFF, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h1234);
    chk("alu_wr_valid", 64'(wr_valid), 64'd1);
    chk("alu_wr_reg",   64'(wr_reg),   64'd5);
    chk("alu_wr_data",  wr_data,       64'h1234);
    chk("alu_busy",     64'(busy),     64'd1);
    tick();
    chk("alu_busy_after", 64'(busy),     64'd0);
    chk("alu_valid_after", 64'(wr_valid), 64'd0);

    // Load formatting, back to back
    enq(5'd6,  64'hDEAD, 64'h0000_0000_0000_80FF, 1'b1, 1'b1, 2'd0, 1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FF80);
    enq(5'd7,  64'hDEAD, 64'h0000_0000_0000_80FF, 1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 64'h0000_0000_0000_0080);
    enq(5'd8,  64'hDEAD, 64'h0000_0000_0000_80FF, 1'b1, 1'b1, 2'd1, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_80FF);
    enq(5'd9,  64'hDEAD, 64'h8765_4321_0000_0000, 1'b1, 1'b1, 2'd2, 1'b0, 3'd4, 64'hFFFF_FFFF_8765_4321);
    enq(5'd10, 64'hDEAD, 64'h0000_0000_ABCD_0000, 1'b1, 1'b1, 2'd1, 1'b1, 3'd3, 64'h0000_0000_0000_ABCD);
    enq(5'd11, 64'hDEAD, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b1, 2'd3, 1'b0, 3'd5, 64'h8123_4567_89AB_CDEF);
    enq(5'd12, 64'hDEAD, 64'hF000_0001_2222_2222, 1'b1, 1'b1, 2'd2, 1'b1, 3'd6, 64'h0000_0000_F000_0001);
    enq(5'd13, 64'hCAFE, 64'h8888_8888_8888_8888, 1'b0, 1'b1, 2'd0, 1'b0, 3'd7, 64'h0000_0000_0000_CAFE);
    drain();

    // Non-writing ops: reg 0, and reg_write=0 even with the port stalled
    enq(5'd0, 64'h55, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h55);
    chk("r0_busy",  64'(busy),     64'd1);
    chk("r0_valid", 64'(wr_valid), 64'd0);
    tick();
    chk("r0_busy_after", 64'(busy), 64'd0);
    wr_ready = 1'b0;
    enq(5'd7, 64'h66, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h66);
    chk("nowr_valid", 64'(wr_valid), 64'd0);
    tick();
    chk("nowr_busy_after", 64'(busy), 64'd0);

    // Backpressure: two entries fill the queue, third waits
    wr_ready = 1'b0;
    enq(5'd1, 64'h111, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h111);
    enq(5'd2, 64'h222, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h222);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_reg = 5'd3; in_result = 64'h333;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wr_valid", 64'(wr_valid), 64'd1);
      chk("stall_wr_reg",   64'(wr_reg),   64'd1);
      chk("stall_wr_data",  wr_data,       64'h111);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    wr_ready = 1'b1;
    enq(5'd3, 64'h333, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h333);
    drain();

    // Reset while stalled with two entries
    wr_ready = 1'b0;
    enq(5'd9,  64'h999, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h999);
    enq(5'd10, 64'hAAA, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'hAAA);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("mid_rst_retire_count", retire_count, 64'd0);
`endif
    wr_ready = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("post_rst_busy",     64'(busy),     64'd0);

    // Ten ops, three of them to register 0
    for (int i = 0; i < 10; i++) begin
      logic [RW-1:0] r;
      r = (i % 4 == 0) ? 5'd0 : RW'(i + 16);
      enq(r, 64'(i * 32'h101), 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'(i * 32'h101));
    end
    drain();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count_10", retire_count, 64'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("retire_count_rst", retire_count, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
